// File: rtl/spi_flash_stream_reader.sv
// SPI mode-0 NOR flash read engine: one address/length request in, a valid/ready
// byte stream out, with SCLK paused at bit 7 while the consumer holds a byte.
module spi_flash_stream_reader #(
    parameter int CLK_DIV        = 1,
    parameter int ADDR_WIDTH     = 24,
    parameter int FAST_READ      = 0,
    parameter int LEN_WIDTH      = 16,
    parameter int CS_HIGH_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  abort,
    output logic [7:0]            data,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  data_last,
    output logic                  busy,
    output logic                  flash_sclk,
    output logic                  flash_cs,
    output logic                  flash_si,
    input  logic                  flash_so
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_DUMMY = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_DESEL = 3'd5;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CSC_W = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
    localparam int TX_W  = 8 + ADDR_WIDTH;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CSC_W-1:0] CSC_LAST = CSC_W'(CS_HIGH_CYCLES - 1);
    localparam logic [7:0] READ_CMD = (ADDR_WIDTH == 32) ?
                                      ((FAST_READ != 0) ? 8'h0C : 8'h13) :
                                      ((FAST_READ != 0) ? 8'h0B : 8'h03);

    logic [2:0]           state;
    logic [DIV_W-1:0]     div_cnt;
    logic [5:0]           bit_cnt;
    logic [5:0]           field_last;
    logic [TX_W-1:0]      tx_sr;
    logic [6:0]           rx_sr;
    logic [LEN_WIDTH-1:0] len_cnt;
    logic [CSC_W-1:0]     cs_cnt;
    logic                 phase_end;
    logic                 stall;
    logic                 rise;
    logic                 bit_end;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE) || data_valid;
    assign phase_end = (div_cnt == DIV_LAST);

    // Only bit 7's low phase may stretch: by then the previous byte must be gone,
    // so the byte completing at the end of bit 7 never lands on an unconsumed one.
    assign stall   = (state == S_DATA) && (bit_cnt == 6'd7) && !flash_sclk &&
                     data_valid && !data_ready;
    assign rise    = !flash_sclk && phase_end && !stall;
    assign bit_end = flash_sclk && phase_end;

    always_comb begin
        field_last = 6'd7;
        if (state == S_ADDR)
            field_last = 6'(ADDR_WIDTH - 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            len_cnt    <= '0;
            cs_cnt     <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            data_last  <= 1'b0;
            flash_sclk <= 1'b0;
            flash_cs   <= 1'b1;
            flash_si   <= 1'b0;
        end else begin
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
                data_last  <= 1'b0;
            end

            if (abort && state != S_IDLE) begin
                state      <= S_DESEL;
                flash_cs   <= 1'b1;
                flash_sclk <= 1'b0;
                flash_si   <= 1'b0;
                data_valid <= 1'b0;
                data_last  <= 1'b0;
                div_cnt    <= '0;
                bit_cnt    <= '0;
                rx_sr      <= '0;
                if (state != S_DESEL)
                    cs_cnt <= CSC_LAST;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (req_valid) begin
                            state    <= S_CMD;
                            flash_cs <= 1'b0;
                            flash_si <= READ_CMD[7];
                            tx_sr    <= {READ_CMD[6:0], req_addr, 1'b0};
                            len_cnt  <= req_len;
                            div_cnt  <= '0;
                            bit_cnt  <= '0;
                        end
                    end

                    S_DESEL: begin
                        if (cs_cnt == '0)
                            state <= S_IDLE;
                        else
                            cs_cnt <= cs_cnt - 1'b1;
                    end

                    S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                        if (rise) begin
                            flash_sclk <= 1'b1;
                            div_cnt    <= '0;
                        end else if (bit_end) begin
                            flash_sclk <= 1'b0;
                            div_cnt    <= '0;
                            bit_cnt    <= bit_cnt + 6'd1;
                            if (state == S_CMD || state == S_ADDR) begin
                                flash_si <= tx_sr[TX_W-1];
                                tx_sr    <= tx_sr << 1;
                            end
                            if (state == S_DATA)
                                rx_sr <= {rx_sr[5:0], flash_so};

                            if (bit_cnt == field_last) begin
                                bit_cnt <= '0;
                                case (state)
                                    S_CMD:   state <= S_ADDR;
                                    S_ADDR: begin
                                        flash_si <= 1'b0;
                                        state    <= (FAST_READ != 0) ? S_DUMMY : S_DATA;
                                    end
                                    S_DUMMY: state <= S_DATA;
                                    default: begin
                                        data       <= {rx_sr, flash_so};
                                        data_valid <= 1'b1;
                                        data_last  <= (len_cnt == '0);
                                        if (len_cnt == '0) begin
                                            state    <= S_DESEL;
                                            flash_cs <= 1'b1;
                                            cs_cnt   <= CSC_LAST;
                                        end else begin
                                            len_cnt <= len_cnt - 1'b1;
                                        end
                                    end
                                endcase
                            end
                        end else if (!phase_end) begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/spi_flash_stream_reader.md
Name: spi_flash_stream_reader

Overview:
- Parametrised SPI (mode 0) read engine for the onboard NOR flash: takes one address/length request and streams the requested bytes out over a valid/ready interface.
- Adds over the single-byte reader:
  - configurable SCLK divider;
  - normal or fast-read command with dummy cycles;
  - 24/32-bit addressing;
  - explicit burst length with `data_last`;
  - consumer backpressure by pausing SCLK;
  - abort;
  - guaranteed CS-high time between transactions.
- Sits between the video/asset fetch logic and the flash pins.

Parameters:
- `CLK_DIV`, 1: SCLK half-period in `clk` cycles (≥1). One SPI bit = 2*`CLK_DIV` cycles.
- `ADDR_WIDTH`, 24: 24 or 32 only. 32 selects 4-byte-address commands.
- `FAST_READ`, 0: 0 = command 0x03 (0x13 if 32-bit), no dummy. 1 = 0x0B (0x0C if 32-bit) plus 8 dummy clocks.
- `LEN_WIDTH`, 16: width of `req_len`.
- `CS_HIGH_CYCLES`, 4: minimum `flash_cs` high time in `clk` cycles after any transaction (≥1).

Ports:
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: high only in IDLE. Request accepted on `req_valid && req_ready`.
- `req_addr` input `ADDR_WIDTH`: start byte address.
- `req_len` input `LEN_WIDTH`: byte count minus one (0 = 1 byte).
- `abort` input 1: terminate the current transaction.
- `data` output 8: received byte, MSB first on wire.
- `data_valid` output 1: `data` holds an unconsumed byte.
- `data_ready` input 1: consumer accepts on `data_valid && data_ready`.
- `data_last` output 1: qualifies the final byte of the request.
- `busy` output 1: `state != IDLE || data_valid`.
- `flash_sclk` output 1: SPI clock, idle low.
- `flash_cs` output 1: chip select, active low.
- `flash_si` output 1: controller to flash.
- `flash_so` input 1: flash to controller.

Behaviour:
- **Reset values:** `flash_cs`=1, `flash_sclk`=0, `flash_si`=0, `data`=0, `data_valid`=0, `data_last`=0, state=IDLE, CS-high counter already satisfied. Reset mid-transaction forces these values immediately (async).
- **States:** IDLE, CMD (8 bits), ADDR (`ADDR_WIDTH` bits), DUMMY (8 clocks, only when `FAST_READ`=1), DATA, DESELECT.
- **Bit timing:**
  - Each bit has a low phase (`CLK_DIV` cycles, SCLK=0) then a high phase (`CLK_DIV` cycles, SCLK=1).
  - `flash_si` changes only at the start of a low phase.
  - `flash_so` is sampled on the last cycle of each high phase.
  - All fields are sent MSB first. `flash_si`=0 during DUMMY and DATA.
- **Accept:** on the accepting edge, latch `addr`/`len`, then `flash_cs`=0 and present the command MSB on `flash_si` in the next cycle. The first SCLK rise comes `CLK_DIV` cycles later.
- **First-byte latency:** with no backpressure, `data_valid` first rises exactly 2*`CLK_DIV`*(16+`ADDR_WIDTH`+D) cycles after the accepting edge, where D=8 if `FAST_READ`=1, else 0. Example: 80 cycles for defaults.
- **DATA:**
  - Bytes shift into an internal register. On each 8th sample the byte moves to `data` with `data_valid`=1, and `data_last`=1 if the remaining count is 0.
  - The byte counter decrements per completed byte.
  - After the last byte's final sample: SCLK stays low, go to DESELECT (`flash_cs`=1).
- **Backpressure:**
  - If at the end of bit 7's low phase `data_valid`=1 and `data_ready`=0, the low phase is extended. SCLK holds 0 and CS holds 0 until `data_ready`.
  - Bits 0–6 never stall. No byte is ever overwritten or dropped.
  - Holding is legal because SPI is static.
- **Back-to-back output:** a consumer holding `data_ready`=1 sees one byte every 16*`CLK_DIV` cycles.
- **Abort:**
  - In any non-IDLE state: next cycle `flash_cs`=1, `flash_sclk`=0, discard the partial byte, clear `data_valid`/`data_last`, enter DESELECT.
  - Abort in IDLE is ignored.
  - Abort wins over a simultaneous byte completion.
- **DESELECT:** `flash_cs` stays high for `CS_HIGH_CYCLES`, then IDLE. `req_ready`=0 throughout. `data_valid` from the last byte may remain set into IDLE until consumed.
- **Address boundary:** no wrap handling. The flash's internal address increment applies.
- **`req_len` = max:** 2^`LEN_WIDTH` bytes are delivered; the counter does not overflow.
- **Request while busy:** ignored (`req_ready`=0). `req_*` is sampled only on accept.

Test Plan:
- **Single byte, defaults:** req addr 0x012345, len 0, `data_ready`=1; flash model returns 0xA5. Expect `flash_si` stream 0x03,0x01,0x23,0x45 MSB first; `data`=0xA5 with `data_valid`=`data_last`=1 exactly 80 cycles after accept; CS high ≥4 cycles after.
- **Fast read, 32-bit, `CLK_DIV`=2:** req 0x00ABCDEF, len 3. Expect command 0x0C, 32 address bits, 8 dummy clocks with SCLK period 4 cycles; bytes 0..3 delivered in order, `data_last` only on the 4th.
- **Backpressure:** len 7, `data_ready` low for 50 cycles after the first byte. Expect SCLK held low at bit 7 of byte 2 with CS low; all 8 bytes intact and in order after release; no SCLK edge while stalled.
- **Abort mid-ADDR and mid-DATA:** expect CS high the next cycle, `data_valid`=0, `req_ready` low for exactly `CS_HIGH_CYCLES`; a new request afterwards completes correctly.
- **Async reset mid-DATA:** `reset` pulse between clock edges. Expect CS=1, SCLK=0, `data_valid`=0 immediately; normal operation on release.
- **`req_valid` held during a transaction:** no second accept until IDLE; then exactly one accept.
